rv_mini_core: RTL and testbench

- Multi-cycle, non-pipelined RV32I-subset processor core with a single shared instruction/data bus in simple Wishbone-style request/acknowledge form.
- Fetches instructions from the bus, executes LW, SW and a small integer ALU subset against a 32x32 register file, and accesses data memory over the same bus.
- Sits at the top of the CPU subsystem; the bus connects to a memory/interconnect slave.

---
 rtl/rv_mini_core_if.sv | 23 ++
 rtl/rv_mini_core.sv | 127 ++++++++++++
 tb/tb_rv_mini_core.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_mini_core_if.sv
// Shared instruction/data bus between the core (master) and memory (slave).
// Request is held on wb_cs until wb_ack; the slave may stall for any number of cycles.
interface rv_mini_core_if #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32
);
  logic [ADDR_SIZE-1:0] wb_addr;
  logic                 wb_cs;
  logic                 wb_we;
  logic [WORD_SIZE-1:0] wb_wdata;
  logic [WORD_SIZE-1:0] wb_rdata;
  logic                 wb_ack;

  modport master (
    output wb_addr, wb_cs, wb_we, wb_wdata,
    input  wb_rdata, wb_ack
  );

  modport slave (
    input  wb_addr, wb_cs, wb_we, wb_wdata,
    output wb_rdata, wb_ack
  );
endinterface

// File: rtl/rv_mini_core.sv
// Multi-cycle RV32I-subset core (LW/SW/ADD/SUB/AND/OR/XOR/ADDI): fetch, decode, mem|exec; 3+ cycles per instr.
// Stalls in FETCH/MEM with all bus outputs held stable until the slave acks.
module rv_mini_core #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  rv_mini_core_if.master  wb
);

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_MEM    = 2'd2;
  localparam logic [1:0] ST_EXEC   = 2'd3;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_ALUI  = 7'b0010011;

  logic [1:0]           state;
  logic [ADDR_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] ir;
  logic [WORD_SIZE-1:0] regs [32];

  logic [6:0]           opcode;
  logic [4:0]           rd, rs1, rs2;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [WORD_SIZE-1:0] imm_i, imm_s, mem_imm;
  logic [ADDR_SIZE-1:0] eff_addr;
  logic                 is_lw, is_sw;
  logic                 alu_vld;
  logic [WORD_SIZE-1:0] alu_res;

  assign opcode  = ir[6:0];
  assign rd      = ir[11:7];
  assign funct3  = ir[14:12];
  assign rs1     = ir[19:15];
  assign rs2     = ir[24:20];
  assign funct7  = ir[31:25];
  assign imm_i   = {{(WORD_SIZE-12){ir[31]}}, ir[31:20]};
  assign imm_s   = {{(WORD_SIZE-12){ir[31]}}, ir[31:25], ir[11:7]};
  assign is_lw   = (opcode == OP_LOAD)  && (funct3 == 3'b010);
  assign is_sw   = (opcode == OP_STORE) && (funct3 == 3'b010);
  assign mem_imm = is_sw ? imm_s : imm_i;
  // x0 is never written, so regs[0] reads back as zero without a special case.
  assign eff_addr = ADDR_SIZE'(regs[rs1] + mem_imm);

  always_comb begin
    alu_vld = 1'b0;
    alu_res = '0;
    if (opcode == OP_ALU) begin
      if (funct7 == 7'b0000000) begin
        unique case (funct3)
          3'b000: begin alu_vld = 1'b1; alu_res = regs[rs1] + regs[rs2]; end
          3'b111: begin alu_vld = 1'b1; alu_res = regs[rs1] & regs[rs2]; end
          3'b110: begin alu_vld = 1'b1; alu_res = regs[rs1] | regs[rs2]; end
          3'b100: begin alu_vld = 1'b1; alu_res = regs[rs1] ^ regs[rs2]; end
          default: ;
        endcase
      end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
        alu_vld = 1'b1;
        alu_res = regs[rs1] - regs[rs2];
      end
    end else if (opcode == OP_ALUI && funct3 == 3'b000) begin
      alu_vld = 1'b1;
      alu_res = regs[rs1] + imm_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_FETCH;
      pc          <= '0;
      ir          <= '0;
      wb.wb_cs    <= 1'b0;
      wb.wb_we    <= 1'b0;
      wb.wb_addr  <= '0;
      wb.wb_wdata <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      unique case (state)
        ST_FETCH: begin
          if (!wb.wb_cs) begin
            wb.wb_cs   <= 1'b1;
            wb.wb_we   <= 1'b0;
            wb.wb_addr <= pc;
          end else if (wb.wb_ack) begin
            ir       <= wb.wb_rdata;
            wb.wb_cs <= 1'b0;
            state    <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          // Data request is launched here so MEM starts with the bus already driven.
          if (is_lw || is_sw) begin
            wb.wb_cs   <= 1'b1;
            wb.wb_we   <= is_sw;
            wb.wb_addr <= eff_addr;
            if (is_sw) wb.wb_wdata <= regs[rs2];
            state <= ST_MEM;
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_MEM: begin
          if (wb.wb_ack) begin
            if (is_lw && rd != 5'd0) regs[rd] <= wb.wb_rdata;
            wb.wb_cs <= 1'b0;
            wb.wb_we <= 1'b0;
            pc       <= pc + ADDR_SIZE'(4);
            state    <= ST_FETCH;
          end
        end
        ST_EXEC: begin
          if (alu_vld && rd != 5'd0) regs[rd] <= alu_res;
          pc    <= pc + ADDR_SIZE'(4);
          state <= ST_FETCH;
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_mini_core.sv
// Bench for rv_mini_core: directed vector table, async-reset corner, then random program vs ISA model.
module tb_rv_mini_core;

  logic tb_clk;
  logic rst_n;

  rv_mini_core_if #(.ADDR_SIZE(32), .WORD_SIZE(32)) bus ();

  rv_mini_core #(.ADDR_SIZE(32), .WORD_SIZE(32)) dut (
    .clk   (tb_clk),
    .rst_n (rst_n),
    .wb    (bus)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] ld_data;
    int          fw;
    int          dw;
    logic        mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } vec_t;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rreg(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : m_regs[r];
  endfunction

  // ISA-level reference: returns the expected data access and retires the instruction.
  task automatic model_step(input logic [31:0] ins, input logic [31:0] ld,
                            output logic mem, output logic we,
                            output logic [31:0] addr, output logic [31:0] wd);
    logic [31:0] a, b, immi, imms, res;
    logic        wr;
    a    = rreg(ins[19:15]);
    b    = rreg(ins[24:20]);
    immi = {{20{ins[31]}}, ins[31:20]};
    imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    mem = 0; we = 0; addr = 0; wd = 0; wr = 0; res = 0;
    if (ins[6:0] == 7'h03 && ins[14:12] == 3'd2) begin
      mem = 1; addr = a + immi; res = ld; wr = 1;
    end else if (ins[6:0] == 7'h23 && ins[14:12] == 3'd2) begin
      mem = 1; we = 1; addr = a + imms; wd = b;
    end else if (ins[6:0] == 7'h33) begin
      wr = 1;
      case ({ins[31:25], ins[14:12]})
        10'h000: res = a + b;
        10'h100: res = a - b;
        10'h007: res = a & b;
        10'h006: res = a | b;
        10'h004: res = a ^ b;
        default: wr = 0;
      endcase
    end else if (ins[6:0] == 7'h13 && ins[14:12] == 3'd0) begin
      wr = 1; res = a + immi;
    end
    if (wr && ins[11:7] != 5'd0) m_regs[ins[11:7]] = res;
    m_pc = m_pc + 32'd4;
  endtask

  // Slave side of one bus transaction; entered and left just after a falling edge.
  task automatic bus_txn(input string name, input logic exp_we, input logic [31:0] exp_addr,
                         input logic [31:0] exp_wdata, input int waits,
                         input logic [31:0] rdata, input logic do_ack);
    int          n;
    logic        ok;
    logic [31:0] a0, d0;
    logic        w0;
    n = 0;
    while (!bus.wb_cs && n < 50) begin
      @(negedge tb_clk);
      n++;
    end
    chk({name, " cs"}, 32'(bus.wb_cs), 32'd1);
    if (!bus.wb_cs) return;
    chk({name, " we"}, 32'(bus.wb_we), 32'(exp_we));
    chk({name, " addr"}, bus.wb_addr, exp_addr);
    if (exp_we) chk({name, " wdata"}, bus.wb_wdata, exp_wdata);
    a0 = bus.wb_addr; d0 = bus.wb_wdata; w0 = bus.wb_we;
    ok = 1'b1;
    for (int i = 0; i < waits; i++) begin
      @(negedge tb_clk);
      if (!bus.wb_cs || bus.wb_addr !== a0 || bus.wb_we !== w0 || (w0 && bus.wb_wdata !== d0))
        ok = 1'b0;
    end
    if (waits > 0) chk({name, " stable"}, 32'(ok), 32'd1);
    if (!do_ack) return;
    bus.wb_ack   = 1'b1;
    bus.wb_rdata = rdata;
    @(negedge tb_clk);
    bus.wb_ack   = 1'b0;
    bus.wb_rdata = $urandom;
    chk({name, " cs drop"}, 32'(bus.wb_cs), 32'd0);
  endtask

  task automatic exec_instr(input logic [31:0] instr, input logic [31:0] ld, input int fw,
                            input int dw, input logic use_tbl, input vec_t v);
    logic        mem, we;
    logic [31:0] ea, wd, fpc;
    fpc = m_pc;
    model_step(instr, ld, mem, we, ea, wd);
    if (use_tbl) begin
      mem = v.mem; we = v.we; ea = v.addr; wd = v.wdata;
    end
    bus_txn("fetch", 1'b0, fpc, 32'd0, fw, instr, 1'b1);
    if (mem) bus_txn(we ? "store" : "load", we, ea, wd, dw, ld, 1'b1);
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    rd  = 5'($urandom_range(0, 31));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    imm = 12'($urandom);
    case ($urandom_range(0, 9))
      0, 1: return enc_i(imm, rs1, 3'b010, rd, 7'h03);
      2, 3: return enc_s(imm, rs2, rs1);
      4:    return enc_r(7'h00, rs2, rs1, 3'b000, rd);
      5:    return enc_r(7'h20, rs2, rs1, 3'b000, rd);
      6:    return enc_r(7'h00, rs2, rs1, ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b110, rd);
      7:    return enc_r(7'h00, rs2, rs1, 3'b100, rd);
      8:    return enc_i(imm, rs1, 3'b000, rd, 7'h13);
      default: begin
        case ($urandom_range(0, 3))
          0: return {20'($urandom), rd, 7'h37};
          1: return enc_i(imm, rs1, 3'b000, rd, 7'h03);
          2: return enc_r(7'h01, rs2, rs1, 3'b000, rd);
          default: return enc_i(imm, rs1, 3'b001, rd, 7'h13);
        endcase
      end
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [16];
    vec_t none;
    tbl[0]  = '{32'h07F02083, 32'hFFFFF000, 1, 0, 1'b1, 1'b0, 32'h0000007F, 32'h0};
    tbl[1]  = '{32'h07E02103, 32'h00000FFF, 0, 2, 1'b1, 1'b0, 32'h0000007E, 32'h0};
    tbl[2]  = '{32'h002081B3, 32'h0,        0, 0, 1'b0, 1'b0, 32'h0,        32'h0};
    tbl[3]  = '{32'h00302823, 32'h0,        2, 3, 1'b1, 1'b1, 32'h00000010, 32'hFFFFFFFF};
    tbl[4]  = '{32'h00102223, 32'h0,        0, 0, 1'b1, 1'b1, 32'h00000004, 32'hFFFFF000};
    tbl[5]  = '{32'h00202423, 32'h0,        1, 1, 1'b1, 1'b1, 32'h00000008, 32'h00000FFF};
    tbl[6]  = '{32'h00500013, 32'h0,        0, 0, 1'b0, 1'b0, 32'h0,        32'h0};
    tbl[7]  = '{32'h00000233, 32'h0,        0, 0, 1'b0, 1'b0, 32'h0,        32'h0};
    tbl[8]  = '{32'h00402023, 32'h0,        0, 0, 1'b1, 1'b1, 32'h00000000, 32'h00000000};
    tbl[9]  = '{32'h10000093, 32'h0,        0, 0, 1'b0, 1'b0, 32'h0,        32'h0};
    tbl[10] = '{32'hFFF0A283, 32'h12345678, 0, 1, 1'b1, 1'b0, 32'h000000FF, 32'h0};
    tbl[11] = '{32'h00502023, 32'h0,        0, 0, 1'b1, 1'b1, 32'h00000000, 32'h12345678};
    tbl[12] = '{32'h40120333, 32'h0,        0, 0, 1'b0, 1'b0, 32'h0,        32'h0};
    tbl[13] = '{32'h00602023, 32'h0,        0, 0, 1'b1, 1'b1, 32'h00000000, 32'hFFFFFF00};
    tbl[14] = '{32'hFE60A823, 32'h0,        0, 2, 1'b1, 1'b1, 32'h000000F0, 32'hFFFFFF00};
    tbl[15] = '{32'h00000383, 32'h0,        1, 0, 1'b0, 1'b0, 32'h0,        32'h0};
    none    = '{32'h0, 32'h0, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0};

    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    bus.wb_ack   = 1'b0;
    bus.wb_rdata = 32'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Outputs held at zero through two reset cycles, first request one edge after release.
    for (int i = 0; i < 2; i++) begin
      @(negedge tb_clk);
      chk("reset cs", 32'(bus.wb_cs), 32'd0);
      chk("reset we", 32'(bus.wb_we), 32'd0);
      chk("reset addr", bus.wb_addr, 32'd0);
      chk("reset wdata", bus.wb_wdata, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge tb_clk);
    chk("first fetch cs", 32'(bus.wb_cs), 32'd1);
    chk("first fetch addr", bus.wb_addr, 32'd0);

    for (int i = 0; i < 16; i++)
      exec_instr(tbl[i].instr, tbl[i].ld_data, tbl[i].fw, tbl[i].dw, 1'b1, tbl[i]);

    // Reset while a load is pending: request must vanish without a clock edge.
    bus_txn("fetch", 1'b0, m_pc, 32'd0, 0, enc_i(12'h020, 5'd0, 3'b010, 5'd6, 7'h03), 1'b1);
    bus_txn("pending load", 1'b0, 32'h00000020, 32'd0, 2, 32'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async reset cs", 32'(bus.wb_cs), 32'd0);
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    @(negedge tb_clk);
    chk("async reset addr", bus.wb_addr, 32'd0);
    @(negedge tb_clk);
    rst_n = 1'b1;
    @(negedge tb_clk);
    exec_instr(enc_s(12'h000, 5'd1, 5'd0), 32'd0, 0, 0, 1'b0, none);

    for (int i = 0; i < 300; i++)
      exec_instr(rand_instr(), $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, none);

    for (int r = 1; r < 32; r++)
      exec_instr(enc_s(12'($urandom), 5'(r), 5'd0), 32'd0, 0, 0, 1'b0, none);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
